// File: rtl/egress_buffer.sv
// Per-port egress FIFO behind the fabric output mux: filters packets by target,
// drains first-word-fall-through over valid/ready, and tracks drops and misroutes.
module egress_buffer #(
    parameter int DEPTH      = 4,
    parameter int PORT_ID    = 0,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [ADDR_WIDTH-1:0]     in_source,
    input  logic [ADDR_WIDTH-1:0]     in_target,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_WIDTH-1:0]     out_source,
    output logic [ADDR_WIDTH-1:0]     out_target,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic [CNT_WIDTH-1:0]      drop_cnt,
    output logic [CNT_WIDTH-1:0]      misroute_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] PORT_MASK = ADDR_WIDTH'(1) << PORT_ID;

    logic [ADDR_WIDTH-1:0] src_mem  [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic [CNT_WIDTH-1:0] mis_q, mis_d;

    logic match, push, pop, drop, misroute;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = !empty;
    assign match     = (in_target == PORT_MASK);
    assign pop       = out_valid & out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push      = in_valid & match & (!full | pop);
    assign drop      = in_valid & match & full & !pop;
    assign misroute  = in_valid & !match;

    assign out_source   = src_mem[head_q];
    assign out_target   = tgt_mem[head_q];
    assign out_data     = data_mem[head_q];
    assign count        = count_q;
    assign drop_cnt     = drop_q;
    assign misroute_cnt = mis_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = drop_q;
        mis_d   = mis_q;
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop && drop_q != '1)   drop_d = drop_q + CNT_WIDTH'(1);
        if (misroute && mis_q != '1) mis_d = mis_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            mis_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            mis_q   <= mis_d;
        end
    end

    // Storage is not reset; the write is gated by rst so a reset-cycle packet is never kept.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            src_mem[tail_q]  <= in_source;
            tgt_mem[tail_q]  <= in_target;
            data_mem[tail_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_egress_buffer.sv
// Directed bench for egress_buffer (DEPTH=4, PORT_ID=2); a second instance with
// CNT_WIDTH=2 shares the stimulus to exercise counter saturation.
module tb_egress_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_source;
    logic [3:0] in_target;
    logic [7:0] in_data;
    logic       out_ready;

    logic       out_valid;
    logic [3:0] out_source, out_target;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       full, empty;
    logic [7:0] drop_cnt, misroute_cnt;

    logic       s_out_valid;
    logic [3:0] s_out_source, s_out_target;
    logic [7:0] s_out_data;
    logic [2:0] s_count;
    logic       s_full, s_empty;
    logic [1:0] s_drop_cnt, s_misroute_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    egress_buffer #(.DEPTH(4), .PORT_ID(2), .ADDR_WIDTH(4), .DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_source(in_source),
        .in_target(in_target), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_source(out_source), .out_target(out_target),
        .out_data(out_data), .count(count), .full(full), .empty(empty),
        .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt)
    );

    egress_buffer #(.DEPTH(4), .PORT_ID(2), .ADDR_WIDTH(4), .DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_source(in_source),
        .in_target(in_target), .in_data(in_data), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_source(s_out_source), .out_target(s_out_target),
        .out_data(s_out_data), .count(s_count), .full(s_full), .empty(s_empty),
        .drop_cnt(s_drop_cnt), .misroute_cnt(s_misroute_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] src, input logic [3:0] tgt, input logic [7:0] d);
        in_valid  = v;
        in_source = src;
        in_target = tgt;
        in_data   = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'b0000, 4'b0000, 8'h00);
        tick();
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_mis", misroute_cnt, 0);

        // single packet, 1-cycle latency
        drive(1'b1, 4'b0001, 4'b0100, 8'hAA);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 8'h00);
        chk("one_valid", out_valid, 1);
        chk("one_data", out_data, 8'hAA);
        chk("one_src", out_source, 4'b0001);
        chk("one_tgt", out_target, 4'b0100);
        chk("one_count", count, 1);
        chk("one_empty", empty, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("one_drained", empty, 1);

        // overflow: 5 packets into 4 slots
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 4'b0010, 4'b0100, 8'(i));
            tick();
        end
        drive(1'b0, 4'b0000, 4'b0000, 8'h00);
        chk("ovf_count", count, 4);
        chk("ovf_full", full, 1);
        chk("ovf_drop", drop_cnt, 1);
        tick();
        chk("ovf_head_stable", out_data, 8'h01);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, 32'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        // full with simultaneous pop accepts the new packet
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b0001, 4'b0100, 8'h11 + 8'(i));
            tick();
        end
        chk("refill_full", full, 1);
        out_ready = 1'b1;
        drive(1'b1, 4'b1000, 4'b0100, 8'h77);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 8'h00);
        chk("fullpop_count", count, 4);
        chk("fullpop_drop", drop_cnt, 1);
        chk("fullpop_d0", out_data, 8'h12);
        tick();
        chk("fullpop_d1", out_data, 8'h13);
        tick();
        chk("fullpop_d2", out_data, 8'h14);
        tick();
        chk("fullpop_d3", out_data, 8'h77);
        chk("fullpop_src3", out_source, 4'b1000);
        tick();
        out_ready = 1'b0;
        chk("fullpop_empty", empty, 1);

        // misroutes
        do_reset();
        drive(1'b1, 4'b0001, 4'b1000, 8'h21);
        tick();
        chk("mis1_valid", out_valid, 0);
        drive(1'b1, 4'b0001, 4'b0000, 8'h22);
        tick();
        chk("mis2_valid", out_valid, 0);
        drive(1'b1, 4'b0001, 4'b0110, 8'h23);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 8'h00);
        chk("mis_cnt", misroute_cnt, 3);
        chk("mis_count", count, 0);
        chk("mis_valid", out_valid, 0);
        chk("mis_drop", drop_cnt, 0);
        chk("sat_mis3", s_misroute_cnt, 3);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'b0001, 4'b0001, 8'h24);
            tick();
        end
        drive(1'b0, 4'b0000, 4'b0000, 8'h00);
        chk("mis_cnt5", misroute_cnt, 5);
        chk("sat_mis_hold", s_misroute_cnt, 3);
        chk("sat_drop", s_drop_cnt, 0);

        // reset mid-operation with concurrent push/pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0001, 4'b0100, 8'h40 + 8'(i));
            tick();
        end
        chk("pre_rst_count", count, 3);
        out_ready = 1'b1;
        drive(1'b1, 4'b0001, 4'b0100, 8'h4F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'b0000, 4'b0000, 8'h00);
        chk("midrst_count", count, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_drop", drop_cnt, 0);
        chk("midrst_mis", misroute_cnt, 0);
        tick();
        chk("midrst_not_stored", count, 0);
        chk("midrst_empty", empty, 1);

        // streaming with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'b0010, 4'b0100, 8'h30 + 8'(i));
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, 32'(8'h30 + 8'(i)));
            chk("stream_count", count, 1);
        end
        drive(1'b0, 4'b0000, 4'b0000, 8'h00);
        tick();
        chk("stream_end_count", count, 0);
        chk("stream_drop", drop_cnt, 0);
        tick();
        chk("idle_ready_count", count, 0);
        chk("idle_ready_valid", out_valid, 0);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
